// File: rtl/haraka_s_pkg.sv
// Shared definitions for the Haraka-S sponge: sponge controller states,
// permutation geometry and the Haraka-512 round-constant table.
// Round constants are selected outside the controller as rc[8*round_idx +: 8].
package haraka_s_pkg;

  localparam int NUM_ROUNDS = 5;
  localparam int RATE_BYTES = 32;
  localparam int ROUND_W    = 3;
  localparam int RC_WORDS   = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM_A,
    ST_SQUEEZE,
    ST_PERM_S,
    ST_DONE
  } sponge_state_t;

  // Eight 128-bit constants per round, five rounds.
  localparam logic [127:0] HARAKA_RC [RC_WORDS] = '{
    128'h0684704ce620c00ab2c5fef075817b9d, 128'h8b66b4e188f3a06b640f6ba42f08f717,
    128'h3402de2d53f28498cf029d609f029114, 128'h0ed6eae62e7b4f08bbf3bcaffd5b4f79,
    128'hcbcfb0cb4872448b79eecd1cbe397044, 128'h7eeacdee6e9032b78d5335ed2b8a057b,
    128'h67c28f435e2e7cd0e2412761da4fef1b, 128'h2924d9b0afcacc07675ffde21fc70b3b,
    128'hab4d63f1e6867fe9ecdb8fcab9d465ee, 128'h1c30bf84d4b7cd645b2a404fad037e33,
    128'hb2cc0bb9941723bf69028b2e8df69800, 128'hfa0478a6de6f55724aaa9ec85c9d2d8a,
    128'hdfb49f2b6b772a120efa4f2e29129fd4, 128'h1ea10344f449a23632d611aebb6a12ee,
    128'haf0449884b0500845f9600c99ca8eca6, 128'h21025ed89d199c4f78a2c7e327e593ec,
    128'hbf3aaaf8a759c9b7b9282ecd82d40173, 128'h6260700d6186b01737f2efd910307d6b,
    128'h5aca45c22130044381c29153f6fc9ac6, 128'h9223973c226b68bb2caf92e836d1943a,
    128'hd3bf9238225886eb6cbab958e51071b4, 128'hdb863ce5aef0c677933dfddd24e1128d,
    128'hbb606268ffeba09c83e48de3cb2212b1, 128'h734bd3dce2e4d19c2db91a4ec72bf77d,
    128'h43bb47c361301b434b1415c42cb3924e, 128'hdba775a8e707eff603b231dd16eb6899,
    128'h6df3614b3c7559778e5e23027eca472c, 128'hcda75a17d6de7d776d1be5b9b88617f9,
    128'hec6b43f06ba8e9aa9d6c069da946ee5d, 128'hcb1e6950f957332ba25311593bf327c1,
    128'h2cee0c7500da619ce4ed0353600ed0d9, 128'hf0b1a5a196e90cab80bbbabc63a4a350,
    128'hae3db1025e962988ab0dde30938dca39, 128'h17bb8f38d554a40b8814f3a82e75b442,
    128'h34bb8a5b5f427fd7aeb6b779360a16f6, 128'h26f65241cbe5543843ce5918ffbaafde,
    128'h4ce99a54b9f3026aa2ca9cf7839ec978, 128'hae51a51a1bdff7be40c06e2822901235,
    128'ha0c1613cba7ed22bc173bc0f48a659cf, 128'h756acc03022882884ad6bdfde9c59da1
  };

endpackage

// File: rtl/haraka_round_seq.sv
// Round sequencer: after a start pulse, runs NUM_ROUNDS consecutive rounds.
// Latency: round 0 is issued the cycle after start; last_round flags the final one.
// No backpressure: once started the burst always completes (only reset aborts it).
module haraka_round_seq #(
  parameter int NUM_ROUNDS = 5,
  parameter int ROUND_W    = 3
) (
  input  logic               internal_clk,
  input  logic               reset,
  input  logic               start,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               last_round
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  logic               active_q;
  logic [ROUND_W-1:0] cnt_q;

  // Count rounds of the current burst; counter rests at zero when idle.
  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      if (cnt_q == LAST_IDX) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign round_en   = active_q;
  assign round_idx  = active_q ? cnt_q : '0;
  assign last_round = active_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/haraka_s_sponge_ctrl.sv
// Haraka-S sponge sequencer: absorb blocks, permute, squeeze digest_length bytes.
// Latency: block accepted at T -> rounds T+1..T+5 -> ready for next block at T+6.
// Backpressure: blk_ready only in ABSORB; out_valid/out_len held until out_ready.
module haraka_s_sponge_ctrl
  import haraka_s_pkg::*;
#(
  parameter int NUM_ROUNDS = haraka_s_pkg::NUM_ROUNDS,
  parameter int RATE_BYTES = haraka_s_pkg::RATE_BYTES,
  parameter int ROUND_W    = haraka_s_pkg::ROUND_W
) (
  input  logic               internal_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        digest_length,
  input  logic               blk_valid,
  input  logic               blk_last,
  output logic               blk_ready,
  output logic               state_clear,
  output logic               absorb_load,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_len,
  output logic               busy,
  output logic               done
);

  localparam int         REM_W    = $clog2(RATE_BYTES);
  localparam logic [5:0] FULL_LEN = 6'(RATE_BYTES);

  sponge_state_t     state_q, state_d;
  logic [63:0]       blocks_total_q;
  logic [63:0]       sq_cnt_q;
  logic [REM_W-1:0]  rem_q;
  logic              last_seen_q;
  logic              seq_start;
  logic              last_round;
  logic              final_block;

  haraka_round_seq #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_seq (
    .internal_clk (internal_clk),
    .reset        (reset),
    .start        (seq_start),
    .round_en     (round_en),
    .round_idx    (round_idx),
    .last_round   (last_round)
  );

  // State register.
  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    seq_start   = 1'b0;
    state_clear = 1'b0;
    absorb_load = 1'b0;
    blk_ready   = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_clear = 1'b1;
          state_d     = ST_ABSORB;
        end
      end
      ST_ABSORB: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          absorb_load = 1'b1;
          seq_start   = 1'b1;
          state_d     = ST_PERM_A;
        end
      end
      ST_PERM_A: begin
        if (last_round) begin
          if (!last_seen_q)              state_d = ST_ABSORB;
          else if (blocks_total_q == '0) state_d = ST_DONE;
          else                           state_d = ST_SQUEEZE;
        end
      end
      ST_SQUEEZE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // The final squeezed block is not followed by a permutation.
          if (sq_cnt_q + 64'd1 == blocks_total_q) begin
            state_d = ST_DONE;
          end else begin
            seq_start = 1'b1;
            state_d   = ST_PERM_S;
          end
        end
      end
      ST_PERM_S: begin
        if (last_round) state_d = ST_SQUEEZE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hash parameters sampled at start, plus absorb/squeeze progress.
  always_ff @(posedge internal_clk or posedge reset) begin
    if (reset) begin
      blocks_total_q <= '0;
      sq_cnt_q       <= '0;
      rem_q          <= '0;
      last_seen_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        blocks_total_q <= (digest_length >> REM_W) + 64'(|digest_length[REM_W-1:0]);
        rem_q          <= digest_length[REM_W-1:0];
        sq_cnt_q       <= '0;
        last_seen_q    <= 1'b0;
      end
      if (absorb_load)            last_seen_q <= blk_last;
      if (out_valid && out_ready) sq_cnt_q    <= sq_cnt_q + 64'd1;
    end
  end

  // Only the last block of a digest that is not a whole number of rate blocks is short.
  assign final_block = (sq_cnt_q == blocks_total_q - 64'd1);
  assign out_len     = !out_valid                     ? 6'd0 :
                       (final_block && rem_q != '0)   ? 6'(rem_q) : FULL_LEN;
  assign busy        = (state_q != ST_IDLE);

endmodule
